hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/bubble controller for the 5-stage pipeline.
- Decides each cycle whether the F/D register holds (fd_stall), whether the PC updates (pc_en), and whether a bubble is inserted into D/E (de_flush).
- Sources of stall: Tuse/Tnew data hazards against the E and M stages, and a multi-cycle multiply/divide unit that it tracks with an internal busy counter.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the md busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- d_rs  in  5  D-stage rs address.
- d_rt  in  5  D-stage rt address.
- d_tuse_rs  in  2  cycles until rs is needed; 3 = not used.
- d_tuse_rt  in  2  cycles until rt is needed; 3 = not used.
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_wa  in  5  E-stage destination register.
- e_tnew  in  2  cycles until the E result is ready.
- m_wa  in  5  M-stage destination register.
- m_tnew  in  2  cycles until the M result is ready.
- e_md_start  in  1  E-stage instruction starts mult/div this cycle.
- e_md_div  in  1  1 = div/divu, 0 = mult/multu; valid with e_md_start.
- fd_stall  out  1  hold the F/D register.
- pc_en  out  1  PC write enable.
- de_flush  out  1  clear the D/E register (bubble).
- md_busy  out  1  mult/div unit busy.
- stall_cnt  out  PERF_W  stall cycles since reset.

Behaviour:
- Data stall (combinational, same cycle):
  - stall_rs = d_rs!=0 && ((d_rs==e_wa && d_tuse_rs<e_tnew) || (d_rs==m_wa && d_tuse_rs<m_tnew)).
  - stall_rt is identical with rt.
  - Register 0 never stalls.
  - Tuse=3 never stalls, because Tnew ≤ 2.
- MD stall: d_md_use && (md_busy || e_md_start).
- stall = stall_rs | stall_rt | md_stall.
- Outputs from stall: fd_stall = stall; pc_en = !stall; de_flush = stall. All are combinational, with no added latency.
- md counter md_cnt [CNT_W]:
  - Reset value is 0.
  - If e_md_start && md_cnt==0: load e_md_div ? DIV_CYCLES : MULT_CYCLES.
  - Else if md_cnt!=0: decrement.
  - e_md_start while md_cnt!=0 is ignored; the counter keeps counting. The pipeline guarantees this cannot happen, and the ignore is a defined fallback.
- md_busy = (md_cnt != 0), registered-derived.
  - The start cycle itself is covered by the e_md_start term of md_stall.
  - md_busy is high for exactly N cycles after the start edge.
- stall_cnt:
  - Increments on each posedge where stall==1.
  - Saturates at all-ones; no wrap.
  - Reset value is 0.
- Reset:
  - Asynchronous and active-low; clears md_cnt and stall_cnt immediately, including mid-operation.
  - Outputs then follow the inputs combinationally; with md_cnt=0, md_busy=0.
- Simultaneous events:
  - Data and MD stall together count as one stall cycle: stall_cnt +1 only.
  - e_md_start and d_md_use in the same cycle produce a stall.
  - The counter loads on that edge.

Decomposition:
- Shared package pipe_pkg holds:
  - TUSE_NONE=2'd3.
  - Tnew/Tuse width (2).
  - Register address width (5).
  - Reset PC 32'h0000_3000, for consistency with the pipeline registers.
- One natural sub-module: md_busy_counter (load/decrement/busy).
- Hazard compare logic stays inline.

Test Plan:
- Load-use: d_rs=5, d_tuse_rs=0, e_wa=5, e_tnew=2 -> fd_stall=1, pc_en=0, de_flush=1. Next cycle, with e_wa=0, m_wa=5, m_tnew=1 -> still stall. Then m_tnew=0 -> stall=0.
- $0 and no-use: d_rs=0=e_wa, e_tnew=2 -> no stall. d_rt=7=e_wa, d_tuse_rt=3 -> no stall.
- Mult: e_md_start=1, e_md_div=0 with d_md_use=1 -> stall on the start cycle, then md_busy=1 for 5 cycles. Stall drops on the 7th cycle (start + 5 + 1 check).
- Div: e_md_start=1, e_md_div=1; d_md_use=0 -> no stall while md_busy=1 for 10 cycles. d_md_use=1 at cycle 4 -> stall until md_cnt reaches 0.
- Reset mid-div: reset=0 at md_cnt=6 -> md_busy=0 and stall_cnt=0 immediately, without waiting for a clock edge.
- Perf saturation: force PERF_W=4 and hold stall for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types used by the hazard controller and pipeline registers.
package pipe_pkg;

   localparam int REG_AW = 5;
   localparam int T_W    = 2;

   localparam logic [T_W-1:0] TUSE_NONE = 2'd3;
   localparam logic [31:0]    RESET_PC  = 32'h0000_3000;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [T_W-1:0]    tval_t;

   // A read of addr in D collides with an in-flight write that will not be ready in time.
   function automatic logic hazard_hit(input reg_addr_t addr, input tval_t tuse,
                                       input reg_addr_t wa,   input tval_t tnew);
      return (addr != 5'd0) && (addr == wa) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Busy tracker for the multi-cycle multiply/divide unit: loads on start, counts down to idle.
module md_busy_counter #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_div,
   output logic o_busy
);

   logic [CNT_W-1:0] r_cnt;

   // Load on an idle start, otherwise count down; a start while busy is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_start && (r_cnt == {CNT_W{1'b0}})) begin
         r_cnt <= i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (r_cnt != {CNT_W{1'b0}}) begin
         r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_busy = (r_cnt != {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew data hazards, mult/div busy interlock,
// and a saturating stall-cycle performance counter.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic [T_W-1:0]    d_tuse_rs,
   input  logic [T_W-1:0]    d_tuse_rt,
   input  logic              d_md_use,
   input  logic [REG_AW-1:0] e_wa,
   input  logic [T_W-1:0]    e_tnew,
   input  logic [REG_AW-1:0] m_wa,
   input  logic [T_W-1:0]    m_tnew,
   input  logic              e_md_start,
   input  logic              e_md_div,
   output logic              fd_stall,
   output logic              pc_en,
   output logic              de_flush,
   output logic              md_busy,
   output logic [PERF_W-1:0] stall_cnt
);

   logic              w_md_busy;
   logic              w_stall_rs;
   logic              w_stall_rt;
   logic              w_md_stall;
   logic              w_stall;
   logic [PERF_W-1:0] r_stall_cnt;

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_counter (
      .clk     (clk),
      .reset   (reset),
      .i_start (e_md_start),
      .i_div   (e_md_div),
      .o_busy  (w_md_busy)
   );

   // Same-cycle stall decision; the start cycle is covered by e_md_start before busy rises.
   always_comb begin
      w_stall_rs = 1'b0;
      w_stall_rt = 1'b0;
      w_md_stall = 1'b0;
      w_stall_rs = hazard_hit(d_rs, d_tuse_rs, e_wa, e_tnew) |
                   hazard_hit(d_rs, d_tuse_rs, m_wa, m_tnew);
      w_stall_rt = hazard_hit(d_rt, d_tuse_rt, e_wa, e_tnew) |
                   hazard_hit(d_rt, d_tuse_rt, m_wa, m_tnew);
      w_md_stall = d_md_use & (w_md_busy | e_md_start);
   end

   assign w_stall = w_stall_rs | w_stall_rt | w_md_stall;

   // Count stalled cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= {PERF_W{1'b0}};
      end else if (w_stall && (r_stall_cnt != {PERF_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign fd_stall  = w_stall;
   assign pc_en     = ~w_stall;
   assign de_flush  = w_stall;
   assign md_busy   = w_md_busy;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand sequences, random vs. model.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs, d_rt, e_wa, m_wa;
   logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic        d_md_use, e_md_start, e_md_div;
   logic        fd_stall, pc_en, de_flush, md_busy;
   logic [31:0] stall_cnt;
   logic        fd_stall4, pc_en4, de_flush4, md_busy4;
   logic [3:0]  stall_cnt4;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: cycle index, cycle at which the md unit goes idle, stall tallies.
   int          cyc_n  = 0;
   int          md_end = 0;
   int unsigned ref_cnt32 = 0;
   int unsigned ref_cnt4  = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_md_use(d_md_use),
      .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
      .e_md_start(e_md_start), .e_md_div(e_md_div),
      .fd_stall(fd_stall), .pc_en(pc_en), .de_flush(de_flush),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   hazard_ctrl #(.PERF_W(4)) dut4 (
      .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_md_use(d_md_use),
      .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
      .e_md_start(e_md_start), .e_md_div(e_md_div),
      .fd_stall(fd_stall4), .pc_en(pc_en4), .de_flush(de_flush4),
      .md_busy(md_busy4), .stall_cnt(stall_cnt4)
   );

   typedef struct {
      string      name;
      logic [4:0] rs, rt, ewa, mwa;
      logic [1:0] tur, tut, etn, mtn;
      logic       md_use;
      int         exp_stall;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit ref_hit(int a, int tu, int wa, int tn);
      return (a != 0) && (a == wa) && (tu < tn);
   endfunction

   function automatic bit ref_stall(bit busy);
      bit data_st, md_st;
      data_st = ref_hit(d_rs, d_tuse_rs, e_wa, e_tnew) || ref_hit(d_rs, d_tuse_rs, m_wa, m_tnew) ||
                ref_hit(d_rt, d_tuse_rt, e_wa, e_tnew) || ref_hit(d_rt, d_tuse_rt, m_wa, m_tnew);
      md_st   = d_md_use && (busy || e_md_start);
      return data_st || md_st;
   endfunction

   task automatic set_data(input logic [4:0] rs, input logic [1:0] tur, input logic [4:0] rt,
                           input logic [1:0] tut, input logic [4:0] ewa, input logic [1:0] etn,
                           input logic [4:0] mwa, input logic [1:0] mtn);
      d_rs = rs; d_tuse_rs = tur; d_rt = rt; d_tuse_rt = tut;
      e_wa = ewa; e_tnew = etn; m_wa = mwa; m_tnew = mtn;
   endtask

   // Compare one cycle against the model (and optional explicit values), then clock it.
   task automatic cyc(input string nm, input int exp_st, input int exp_busy);
      bit busy, st;
      #1;
      busy = (cyc_n < md_end);
      st   = ref_stall(busy);
      if (exp_st >= 0)   chk({nm, "_stall"}, {31'd0, fd_stall}, exp_st);
      if (exp_busy >= 0) chk({nm, "_busy"},  {31'd0, md_busy},  exp_busy);
      chk({nm, "_fd_stall"}, {31'd0, fd_stall}, {31'd0, st});
      chk({nm, "_pc_en"},    {31'd0, pc_en},    {31'd0, !st});
      chk({nm, "_de_flush"}, {31'd0, de_flush}, {31'd0, st});
      chk({nm, "_md_busy"},  {31'd0, md_busy},  {31'd0, busy});
      chk({nm, "_cnt32"},    stall_cnt,         ref_cnt32);
      chk({nm, "_cnt4"},     {28'd0, stall_cnt4}, ref_cnt4);
      @(posedge clk);
      if (!reset) begin
         md_end = 0; ref_cnt32 = 0; ref_cnt4 = 0;
      end else begin
         if (st) begin
            if (ref_cnt32 != 32'hFFFF_FFFF) ref_cnt32++;
            if (ref_cnt4 < 15) ref_cnt4++;
         end
         if (e_md_start && !busy) md_end = cyc_n + (e_md_div ? 10 : 5) + 1;
      end
      cyc_n++;
      #1;
   endtask

   initial begin
      vecs[0]  = '{"lu_e",       5'd5,  5'd0,  5'd5,  5'd0,  2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 1};
      vecs[1]  = '{"zero_reg",   5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 0};
      vecs[2]  = '{"tuse_none",  5'd0,  5'd7,  5'd7,  5'd0,  2'd3, 2'd3, 2'd2, 2'd0, 1'b0, 0};
      vecs[3]  = '{"rt_e",       5'd0,  5'd7,  5'd7,  5'd0,  2'd3, 2'd1, 2'd2, 2'd0, 1'b0, 1};
      vecs[4]  = '{"rt_e_eq",    5'd0,  5'd7,  5'd7,  5'd0,  2'd3, 2'd1, 2'd1, 2'd0, 1'b0, 0};
      vecs[5]  = '{"rs_m",       5'd9,  5'd0,  5'd0,  5'd9,  2'd1, 2'd3, 2'd0, 2'd2, 1'b0, 1};
      vecs[6]  = '{"rs_m_eq",    5'd9,  5'd0,  5'd0,  5'd9,  2'd1, 2'd3, 2'd0, 2'd1, 1'b0, 0};
      vecs[7]  = '{"no_match",   5'd3,  5'd0,  5'd4,  5'd5,  2'd0, 2'd3, 2'd2, 2'd2, 1'b0, 0};
      vecs[8]  = '{"md_idle",    5'd0,  5'd0,  5'd0,  5'd0,  2'd3, 2'd3, 2'd0, 2'd0, 1'b1, 0};
      vecs[9]  = '{"zero_all",   5'd0,  5'd0,  5'd0,  5'd0,  2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 0};
      vecs[10] = '{"rt_m",       5'd0,  5'd12, 5'd0,  5'd12, 2'd3, 2'd0, 2'd0, 2'd1, 1'b0, 1};

      reset = 1'b0; d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
      set_data(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0);
      @(posedge clk); #1;
      chk("reset_cnt32", stall_cnt, 32'd0);
      chk("reset_busy", {31'd0, md_busy}, 32'd0);
      cyc("reset", 0, 0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         set_data(vecs[i].rs, vecs[i].tur, vecs[i].rt, vecs[i].tut,
                  vecs[i].ewa, vecs[i].etn, vecs[i].mwa, vecs[i].mtn);
         d_md_use = vecs[i].md_use;
         cyc(vecs[i].name, vecs[i].exp_stall, 0);
      end
      d_md_use = 1'b0;

      // Load-use walking from E into M.
      set_data(5'd5, 2'd0, 5'd0, TUSE_NONE, 5'd5, 2'd2, 5'd0, 2'd0);
      cyc("lu_seq0", 1, 0);
      set_data(5'd5, 2'd0, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd5, 2'd1);
      cyc("lu_seq1", 1, 0);
      m_tnew = 2'd0;
      cyc("lu_seq2", 0, 0);
      set_data(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0);

      // Mult with a dependent md instruction waiting in D.
      d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0;
      cyc("mult_start", 1, 0);
      e_md_start = 1'b0;
      for (int k = 1; k <= 5; k++) cyc("mult_busy", 1, 1);
      cyc("mult_done", 0, 0);

      // Div with md use arriving on the fourth busy cycle.
      d_md_use = 1'b0; e_md_start = 1'b1; e_md_div = 1'b1;
      cyc("div_start", 0, 0);
      e_md_start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         d_md_use = (k >= 4);
         cyc("div_busy", (k >= 4) ? 1 : 0, 1);
      end
      cyc("div_done", 0, 0);

      // Start while busy is ignored: busy window follows the first start only.
      d_md_use = 1'b0; e_md_start = 1'b1; e_md_div = 1'b0;
      cyc("ign_start", 0, 0);
      for (int k = 1; k <= 5; k++) begin
         e_md_start = (k == 3); e_md_div = 1'b1;
         cyc("ign_busy", 0, 1);
      end
      e_md_start = 1'b0;
      cyc("ign_done", 0, 0);

      // Asynchronous reset mid-div with four cycles of busy elapsed (count at 6).
      e_md_start = 1'b1; e_md_div = 1'b1;
      cyc("rst_div_start", 0, 0);
      e_md_start = 1'b0;
      for (int k = 1; k <= 4; k++) cyc("rst_div_busy", 0, 1);
      reset = 1'b0;
      #1;
      chk("rst_async_busy", {31'd0, md_busy}, 32'd0);
      chk("rst_async_cnt32", stall_cnt, 32'd0);
      chk("rst_async_cnt4", {28'd0, stall_cnt4}, 32'd0);
      md_end = 0; ref_cnt32 = 0; ref_cnt4 = 0;
      #1;
      reset = 1'b1;
      cyc("post_rst", 0, 0);

      // Saturation of the narrow performance counter.
      set_data(5'd5, 2'd0, 5'd0, TUSE_NONE, 5'd5, 2'd2, 5'd0, 2'd0);
      for (int k = 0; k < 20; k++) cyc("sat", 1, 0);
      chk("sat_cnt4", {28'd0, stall_cnt4}, 32'd15);
      chk("sat_cnt32", stall_cnt, 32'd20);

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         bit busy_now;
         busy_now = (cyc_n < md_end);
         set_data(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
         d_md_use   = ($urandom_range(0, 3) == 0);
         e_md_div   = $urandom_range(0, 1);
         e_md_start = busy_now ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 7) == 0);
         cyc("rand", -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
